// File: rtl/alu_sequencer.sv
// Purpose:  command sequencer for an external 16-bit ALU; small register file + flags.
// Latency:  command accepted at cycle T, response valid at T+2.
// Backpr.:  holds the response until rsp_ready; cmd_ready stays low until it is taken.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only while idle)
//   cmd_load, cmd_op, cmd_rd,
//   cmd_ra, cmd_rb, cmd_imm       command fields (load immediate or ALU op)
//   alu_a, alu_b, alu_op          registered operands/op driven to the external ALU
//   alu_y, alu_c/v/n/z            result and flags back from the ALU
//   rsp_valid/rsp_ready           response handshake
//   rsp_y, rsp_err                result of the completed command, illegal-op flag
//   flags                         {C,V,N,Z} flags register
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_err,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [3:0]       flags_q, flags_d;

  // captured command fields
  logic             load_q, load_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d;

  // registered outputs
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    load_d      = load_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ready_d = cmd_ready_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          load_d      = cmd_load;
          op_d        = cmd_op;
          rd_d        = cmd_rd;
          imm_d       = cmd_imm;
          // Operands are read here so they are stable on the ALU for the whole
          // EXEC cycle; registers cannot change between now and then.
          alu_a_d     = regs_q[cmd_ra];
          alu_b_d     = regs_q[cmd_rb];
          alu_op_d    = cmd_op;
          cmd_ready_d = 1'b0;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (load_q) begin
          regs_d[rd_q] = imm_q;
          rsp_y_d      = imm_q;
          rsp_err_d    = 1'b0;
        end else if (op_q <= 3'd5) begin
          regs_d[rd_q] = alu_y;
          flags_d      = {alu_c, alu_v, alu_n, alu_z};
          rsp_y_d      = alu_y;
          rsp_err_d    = 1'b0;
        end else begin
          // illegal op: nothing architectural changes, only the error response
          rsp_y_d   = '0;
          rsp_err_d = 1'b1;
        end
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      flags_q     <= '0;
      load_q      <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      load_q      <= load_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;
  assign flags     = flags_q;

endmodule
